// File: rtl/led_pwm_fader_if.sv
// LED fader signal bundle: request/enable into the fader; PWM drive,
// brightness level and ramp status out of it.
interface led_pwm_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                led_req;
    logic                enable;
    logic                led_out;
    logic [PWM_BITS-1:0] level;
    logic                busy;

    modport master (
        output led_req,
        output enable,
        input  led_out,
        input  level,
        input  busy
    );

    modport slave (
        input  led_req,
        input  enable,
        output led_out,
        output level,
        output busy
    );
endinterface

// File: rtl/led_pwm_fader.sv
// PWM LED fader: ramps brightness linearly up while the request is held and
// down when it is released, driving the LED pin with a PWM of that level.
module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 97656
) (
    input logic            clk,
    input logic            rst_n,
    led_pwm_fader_if.slave bus
);
    localparam int                  PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL  = '1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_nxt;
    logic                led_q;
    logic                busy_q;
    logic                req;
    logic                ramping;
    logic                step_tick;

    assign req       = bus.led_req & bus.enable;
    assign ramping   = (state == S_UP) || (state == S_DOWN);
    assign step_tick = ramping && (presc == PRESC_LAST);

    // A request change always wins over a coincident step: the level is held
    // on a reversal edge, and the prescaler restarts in the new direction.
    always_comb begin
        state_nxt = state;
        level_nxt = level_q;
        case (state)
            S_OFF: begin
                level_nxt = '0;
                if (req) state_nxt = S_UP;
            end
            S_UP: begin
                if (!req) begin
                    state_nxt = S_DOWN;
                end else if (step_tick) begin
                    if (level_q != MAX_LEVEL) level_nxt = level_q + 1'b1;
                    if (level_nxt == MAX_LEVEL) state_nxt = S_ON;
                end
            end
            S_ON: begin
                level_nxt = MAX_LEVEL;
                if (!req) state_nxt = S_DOWN;
            end
            S_DOWN: begin
                if (req) begin
                    state_nxt = S_UP;
                end else if (step_tick) begin
                    if (level_q != '0) level_nxt = level_q - 1'b1;
                    if (level_nxt == '0) state_nxt = S_OFF;
                end
            end
            default: state_nxt = S_OFF;
        endcase

        if (!ramping || (state_nxt != state) || step_tick)
            presc_nxt = '0;
        else
            presc_nxt = presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OFF;
            level_q <= '0;
            pwm_cnt <= '0;
            presc   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            level_q <= level_nxt;
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= presc_nxt;
            busy_q  <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
            // Full level is forced solid; otherwise L high cycles per period.
            led_q   <= (level_q == MAX_LEVEL) || (pwm_cnt < level_q);
        end
    end

    assign bus.level   = level_q;
    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: ramp/reversal vector table on a fast
// instance (STEP_DIV=3), plus reset, enable and PWM duty sequences.
module tb_led_pwm_fader;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    led_pwm_fader_if #(.PWM_BITS(4)) bus_a ();
    led_pwm_fader_if #(.PWM_BITS(4)) bus_b ();

    led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a)
    );

    led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(64)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic req;
        logic en;
        int   ncyc;
        int   lvl;
        logic bsy;
        logic chk_led;
        logic led;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic e, input int n, input int l,
                       input logic b, input logic c, input logic d);
        vq.push_back('{req: r, en: e, ncyc: n, lvl: l, bsy: b, chk_led: c, led: d});
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input int l, input int b);
        check({tag, "_level"}, int'(bus_a.level), l);
        check({tag, "_busy"}, int'(bus_a.busy), b);
    endtask

    task automatic count_led_a(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hi += int'(bus_a.led_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.led_req = 1'b1;
        bus_a.enable  = 1'b1;
        bus_b.led_req = 1'b1;
        bus_b.enable  = 1'b1;

        // Cumulative edge after reset release noted per row.
        add(1, 1, 1,  0,  1, 0, 0);  // e1: enter UP
        add(1, 1, 2,  0,  1, 0, 0);  // e3: no step yet
        add(1, 1, 1,  1,  1, 0, 0);  // e4: first step
        add(1, 1, 3,  2,  1, 0, 0);  // e7
        add(1, 1, 38, 14, 1, 0, 0);  // e45
        add(1, 1, 1,  15, 0, 0, 0);  // e46: ON
        add(1, 1, 2,  15, 0, 1, 1);  // e48: led solid
        add(0, 1, 1,  15, 1, 0, 0);  // DOWN entry
        add(0, 1, 3,  14, 1, 0, 0);
        add(0, 1, 41, 1,  1, 0, 0);  // +44
        add(0, 1, 1,  0,  0, 0, 0);  // +45: OFF
        add(0, 1, 2,  0,  0, 1, 0);
        add(1, 1, 1,  0,  1, 0, 0);  // UP entry
        add(1, 1, 17, 5,  1, 0, 0);
        add(1, 1, 1,  6,  1, 0, 0);  // +18: level 6
        add(0, 1, 1,  6,  1, 0, 0);  // reversal: held at 6
        add(0, 1, 2,  6,  1, 0, 0);  // prescaler restarted
        add(0, 1, 1,  5,  1, 0, 0);
        add(0, 1, 3,  4,  1, 0, 0);
        add(1, 1, 1,  4,  1, 0, 0);  // reversal: held at 4
        add(1, 1, 2,  4,  1, 0, 0);
        add(1, 1, 1,  5,  1, 0, 0);
        add(1, 1, 12, 9,  1, 0, 0);  // level 9 mid-UP

        @(negedge clk);
        check("reset_level", int'(bus_a.level), 0);
        check("reset_busy", int'(bus_a.busy), 0);
        check("reset_led", int'(bus_a.led_out), 0);
        rst_a = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            bus_a.led_req = vq[i].req;
            bus_a.enable  = vq[i].en;
            repeat (vq[i].ncyc) @(negedge clk);
            check_a($sformatf("vec%0d", i), vq[i].lvl, int'(vq[i].bsy));
            if (vq[i].chk_led)
                check($sformatf("vec%0d_led", i), int'(bus_a.led_out), int'(vq[i].led));
        end

        // Asynchronous reset off-edge, mid-UP at level 9.
        #2 rst_a = 1'b0;
        #1;
        check("async_rst_level", int'(bus_a.level), 0);
        check("async_rst_busy", int'(bus_a.busy), 0);
        check("async_rst_led", int'(bus_a.led_out), 0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check_a("restart_e1", 0, 1);
        repeat (3) @(negedge clk);
        check_a("restart_e4", 1, 1);
        repeat (42) @(negedge clk);
        check_a("restart_on", 15, 0);
        repeat (2) @(negedge clk);
        count_led_a(16, hi);
        check("on_led_high_cycles", hi, 16);

        // enable low while the request is still held.
        bus_a.enable = 1'b0;
        @(negedge clk);
        check_a("en_down_entry", 15, 1);
        repeat (44) @(negedge clk);
        check_a("en_down_44", 1, 1);
        @(negedge clk);
        check_a("en_off", 0, 0);
        repeat (2) @(negedge clk);
        count_led_a(16, hi);
        check("off_led_high_cycles", hi, 0);

        // Duty check on the STEP_DIV=64 instance.
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            hi = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                hi += int'(bus_b.led_out);
            end
            check($sformatf("duty_l0_win%0d", w), hi, 0);
        end
        repeat (144) @(negedge clk);
        check("duty_level3", int'(bus_b.level), 3);
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                hi += int'(bus_b.led_out);
            end
            check($sformatf("duty_l3_win%0d", w), hi, 3);
        end
        check("duty_level4", int'(bus_b.level), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream consumer of the LED blinker's on/off output.
- Turns the hard on/off request into a PWM-driven LED whose brightness ramps linearly up on request and down on release, so the board LED fades instead of snapping.
- Sits between the blink-timing counter and the physical LED pin.
- Single clock domain; the request input comes from a register already in this domain and needs no synchroniser.

Parameters:
- PWM_BITS, 8: width of the brightness level and the PWM counter. MAX_LEVEL = 2^PWM_BITS-1.
- STEP_DIV, 97656: clk cycles per one-LSB brightness step while ramping. Legal range is ≥1; 1 means a step every cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- led_req  in  1  on/off request from the blinker (1 = LED should be lit).
- enable  in  1  fader enable; 0 forces the request inactive.
- led_out  out  1  PWM drive to the LED pin, registered.
- level  out  PWM_BITS  current brightness level, registered.
- busy  out  1  high while a ramp is in progress.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=OFF, level=0, led_out=0, busy=0.
  - PWM counter=0, step prescaler=0.
- Effective request: req = led_req & enable, sampled every rising edge.
- PWM counter:
  - PWM_BITS wide, free-running, wraps MAX_LEVEL->0.
  - Runs in every state.
- Step prescaler:
  - Counts 0..STEP_DIV-1, but only in UP/DOWN.
  - step_tick is asserted in the cycle the prescaler = STEP_DIV-1; the prescaler then wraps to 0.
  - Forced to 0 on every state transition and in OFF/ON.
- State machine (states OFF, UP, ON, DOWN):
  - OFF: level=0. If req -> UP.
  - UP:
    - If !req -> DOWN this edge; level is held, no step applied.
    - Else, on step_tick, level <= level+1. If the new level = MAX_LEVEL -> ON.
  - ON: level=MAX_LEVEL. If !req -> DOWN.
  - DOWN:
    - If req -> UP this edge; level is held.
    - Else, on step_tick, level <= level-1. If the new level = 0 -> OFF.
  - Reversal priority: a req change beats a coincident step_tick (no step that edge).
  - level never wraps: no increment at MAX_LEVEL, no decrement at 0.
- busy: registered, equals (next state is UP or DOWN). It rises on the same edge the state enters UP/DOWN and falls on the edge it enters ON/OFF.
- led_out: registered. led_out <= (level == MAX_LEVEL) | (pwm_cnt < level), using values before the edge.
  - One clk latency from a level change to the duty change.
  - level 0 gives constant 0; MAX_LEVEL gives constant 1; any other level L gives exactly L high cycles per 2^PWM_BITS-cycle period.
- Full-ramp duration: MAX_LEVEL*STEP_DIV cycles from entering UP to entering ON; the same for DOWN to OFF.
- Reset mid-ramp: all state returns to reset values at once. After release, behaviour restarts from OFF even if req is held high (OFF->UP on the first edge).
- enable low during ON or UP: treated exactly as led_req falling, so the LED ramps down. It does not snap off.

Test Plan:
- Params PWM_BITS=4, STEP_DIV=3. Release reset, hold req=1 from cycle 0.
  - State enters UP at edge 1; busy=1.
  - level increments every 3 cycles and reaches 15 at edge 46.
  - State ON, busy=0; led_out then constantly 1.
- From ON, drop led_req.
  - level decrements every 3 cycles to 0 (45 cycles).
  - State OFF, busy=0, led_out constantly 0 afterwards.
- Reversal: during UP at level=6, drop req.
  - Next edge is DOWN with level still 6 and the prescaler restarted.
  - Re-raise req at level=4: UP from 4, and no step is lost or duplicated at either reversal.
- Duty check, PWM_BITS=4, STEP_DIV=64.
  - While level=3, every 16-cycle PWM window shows exactly 3 high cycles of led_out.
  - While level=0, zero high cycles.
- Assert rst_n=0 asynchronously mid-UP at level=9, off-edge.
  - level=0, led_out=0, busy=0 immediately.
  - Release with req=1: OFF->UP on the first edge and the ramp restarts from 0.
- enable=0 while led_req=1 in ON: transition to DOWN, ramp down to OFF over 45 cycles (PWM_BITS=4, STEP_DIV=3).
